// File: rtl/imem_responder.sv
// Instruction-memory fetch responder: one outstanding fetch, WAIT_CYCLES wait states, flush/redirect and program-load port.
// Latency WAIT_CYCLES+1 cycles accept->rsp_valid; response held until rsp_ready, req_ready low while busy or flushing.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] mem [DEPTH_WORDS];

  logic accept;
  logic rsp_hs;
  logic req_err;
  logic ld_ok;

  // Range checks compare the full word index so high addresses never alias into the array.
  assign req_err   = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign ld_ok     = {2'b00, ld_addr[31:2]} < 32'(DEPTH_WORDS);
  assign req_ready = (state == IDLE) && !flush;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_addr[AW+1:2]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        // A handshake coinciding with flush still completes; either way we return to IDLE.
        if (flush || rsp_hs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Capture on the accept edge reads the pre-write array contents, so a same-edge load is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= 32'd0;
      rsp_addr <= 32'd0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_addr <= req_addr;
      rsp_err  <= req_err;
      rsp_data <= req_err ? 32'd0 : mem[req_addr[AW+1:2]];
    end
  end

endmodule
